// File: rtl/rand_range_gen.sv
// Pseudo-random draw source: a free-running Fibonacci LFSR is sampled on request
// and folded into [MIN_VAL, MAX_VAL] one add/subtract step per cycle.
module rand_range_gen #(
    parameter int WIDTH   = 9,
    parameter int SEED    = 20,
    parameter int TAP_A   = 8,
    parameter int TAP_B   = 4,
    parameter int MIN_VAL = 10,
    parameter int MAX_VAL = 380
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             req,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] random
);

    localparam logic [WIDTH-1:0] SEED_W   = WIDTH'(SEED);
    localparam logic [WIDTH-1:0] SEED_NZ  = (SEED_W == '0) ? WIDTH'(1) : SEED_W;
    localparam logic [WIDTH-1:0] RST_RAND = WIDTH'(MIN_VAL);
    localparam logic [WIDTH:0]   MIN_W    = (WIDTH+1)'(MIN_VAL);
    localparam logic [WIDTH:0]   MAX_W    = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0]   RANGE    = (WIDTH+1)'(MAX_VAL - MIN_VAL + 1);

    typedef enum logic {IDLE, FOLD} state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] lfsr, lfsr_d;
    logic [WIDTH:0]   v, v_d;
    logic             busy_d, valid_d;
    logic [WIDTH-1:0] random_d;
    logic             feedback;

    assign feedback = lfsr[TAP_A] ^ lfsr[TAP_B];

    // A zero seed would lock the LFSR, so it falls back to the reset seed.
    always_comb begin
        if (seed_load)
            lfsr_d = (seed_in == '0) ? SEED_NZ : seed_in;
        else
            lfsr_d = {lfsr[WIDTH-2:0], feedback};
    end

    always_comb begin
        state_d  = state;
        v_d      = v;
        busy_d   = busy;
        valid_d  = 1'b0;
        random_d = random;
        if (seed_load) begin
            state_d = IDLE;
            busy_d  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        v_d     = {1'b0, lfsr};
                        busy_d  = 1'b1;
                        state_d = FOLD;
                    end
                end
                FOLD: begin
                    // One fold step always lands in range, so a draw is at most two passes.
                    if (v > MAX_W)
                        v_d = v - RANGE;
                    else if (v < MIN_W)
                        v_d = v + RANGE;
                    else begin
                        random_d = v[WIDTH-1:0];
                        valid_d  = 1'b1;
                        busy_d   = 1'b0;
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            lfsr   <= SEED_NZ;
            v      <= '0;
            busy   <= 1'b0;
            valid  <= 1'b0;
            random <= RST_RAND;
        end else begin
            state  <= state_d;
            lfsr   <= lfsr_d;
            v      <= v_d;
            busy   <= busy_d;
            valid  <= valid_d;
            random <= random_d;
        end
    end

endmodule

// File: tb/tb_rand_range_gen.sv
// Directed bench for rand_range_gen: stimulus pushes expected draws with their due
// cycle; a forked monitor pops and compares on every valid pulse.
module tb_rand_range_gen;

    localparam int WIDTH = 9;

    logic             CLK = 1'b0;
    logic             reset;
    logic             req;
    logic             seed_load;
    logic [WIDTH-1:0] seed_in;
    logic             busy;
    logic             valid;
    logic [WIDTH-1:0] random;

    rand_range_gen dut (
        .CLK       (CLK),
        .reset     (reset),
        .req       (req),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .busy      (busy),
        .valid     (valid),
        .random    (random)
    );

    always #5 CLK = ~CLK;

    longint cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int     val;
        longint due;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_draws = 0;
    bit   range_mode = 1'b0;
    bit   prev_valid = 1'b0;

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge CLK);
            if (valid) begin
                check(busy == 1'b0, "busy_with_valid", longint'(busy), 0);
                check(!prev_valid, "valid_back_to_back", longint'(prev_valid), 0);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check(int'(random) == e.val, "draw_value", longint'(random), e.val);
                    check(cyc == e.due, "draw_latency", cyc, e.due);
                end else if (range_mode) begin
                    n_draws++;
                    check(random >= 10 && random <= 380, "draw_in_range", longint'(random), 10);
                end else begin
                    check(1'b0, "unexpected_valid", longint'(random), 0);
                end
            end
            prev_valid = valid;
        end
    endtask

    initial begin
        bit seen [512];
        int distinct;
        bit saw_zero;
        int cur;

        reset = 1'b0; req = 1'b0; seed_load = 1'b0; seed_in = '0;
        fork monitor(); join_none
        tick(); tick();
        check(busy == 1'b0, "reset_busy", busy, 0);
        check(valid == 1'b0, "reset_valid", valid, 0);
        check(random == 10, "reset_random", random, 10);
        check(dut.lfsr == 20, "reset_lfsr", dut.lfsr, 20);

        // 1: first draw straight out of reset, sample 20 is already in range
        reset = 1'b1; req = 1'b1;
        tick();
        q.push_back('{20, cyc + 1});
        req = 1'b0;
        check(dut.lfsr == 41, "lfsr_first_step", dut.lfsr, 41);
        check(busy == 1'b1, "t1_busy", busy, 1);
        tick(); tick();

        // 2: seed 500 -> one subtract step -> 129, busy for exactly two cycles
        seed_load = 1'b1; seed_in = 9'd500;
        tick();
        seed_load = 1'b0; req = 1'b1;
        tick();
        q.push_back('{129, cyc + 2});
        req = 1'b0;
        check(busy == 1'b1, "t2_busy_c1", busy, 1);
        tick();
        check(busy == 1'b1, "t2_busy_c2", busy, 1);
        check(valid == 1'b0, "t2_valid_early", valid, 0);
        tick();
        check(busy == 1'b0, "t2_busy_end", busy, 0);
        tick();

        // 3: seed 5 -> one add step -> 376; seed 0 -> reload 20
        seed_load = 1'b1; seed_in = 9'd5;
        tick();
        seed_load = 1'b0; req = 1'b1;
        tick();
        q.push_back('{376, cyc + 2});
        req = 1'b0;
        tick(); tick(); tick();
        seed_load = 1'b1; seed_in = 9'd0;
        tick();
        check(dut.lfsr == 20, "zero_seed_lfsr", dut.lfsr, 20);
        seed_load = 1'b0; req = 1'b1;
        tick();
        q.push_back('{20, cyc + 1});
        req = 1'b0;
        tick(); tick();

        // 5: abort a fold with seed_load; the simultaneous req is dropped
        seed_load = 1'b1; seed_in = 9'd500;
        tick();
        seed_load = 1'b0; req = 1'b1;
        tick();
        check(busy == 1'b1, "t5_accepted", busy, 1);
        seed_load = 1'b1; req = 1'b1;
        tick();
        check(busy == 1'b0, "t5_abort_busy", busy, 0);
        check(valid == 1'b0, "t5_abort_valid", valid, 0);
        check(random == 20, "t5_random_held", random, 20);
        seed_load = 1'b0; req = 1'b0;
        tick();
        check(busy == 1'b0, "t5_req_dropped", busy, 0);
        check(valid == 1'b0, "t5_no_valid", valid, 0);
        tick();

        // reset in the middle of a draw
        req = 1'b1;
        tick();
        req = 1'b0;
        check(busy == 1'b1, "mid_reset_busy_before", busy, 1);
        reset = 1'b0;
        #1;
        check(busy == 1'b0, "mid_reset_busy", busy, 0);
        check(random == 10, "mid_reset_random", random, 10);
        check(dut.lfsr == 20, "mid_reset_lfsr", dut.lfsr, 20);
        tick();

        // 4: full period free run
        reset = 1'b1;
        distinct = 0; saw_zero = 1'b0; cur = 0;
        for (int i = 0; i < 511; i++) begin
            tick();
            cur = int'(dut.lfsr);
            if (cur == 0) saw_zero = 1'b1;
            if (!seen[cur]) distinct++;
            seen[cur] = 1'b1;
            if (i < 510) check(cur != 20, "lfsr_early_repeat", cur, 20);
        end
        check(cur == 20, "lfsr_period", cur, 20);
        check(!saw_zero, "lfsr_zero_state", saw_zero, 0);
        check(distinct == 511, "lfsr_distinct", distinct, 511);

        // 6: held req with periodic random reseeds
        range_mode = 1'b1;
        req = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            seed_load = (i % 97 == 0);
            seed_in = WIDTH'($urandom_range(0, 511));
            tick();
        end
        req = 1'b0; seed_load = 1'b0;
        tick(); tick(); tick(); tick();
        check(n_draws > 250, "held_req_draws", n_draws, 250);
        check(q.size() == 0, "missing_valids", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
